// File: rtl/fe_pkg.sv
// GF(2^255-19) element type, constants, reduction helper and the fe_pow state encoding.
package fe_pkg;

    typedef logic [254:0] fe_t;

    localparam fe_t P      = fe_t'((256'd1 << 255) - 256'd19);
    localparam fe_t FE_ONE = fe_t'(1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SQR_GO   = 3'd1,
        ST_SQR_WAIT = 3'd2,
        ST_MUL_GO   = 3'd3,
        ST_MUL_WAIT = 3'd4,
        ST_NEXT     = 3'd5,
        ST_FIN      = 3'd6
    } fe_pow_state_t;

    // 2^255 == 19 (mod p): fold the high part twice, then at most one subtract of p.
    function automatic fe_t fe_reduce(input logic [509:0] x);
        logic [261:0] t1;
        logic [255:0] t2;
        t1 = {7'd0, x[254:0]} + ({7'd0, x[509:255]} * 262'd19);
        t2 = {1'b0, t1[254:0]} + ({249'd0, t1[261:255]} * 256'd19);
        if (t2 >= {1'b0, P}) begin
            t2 = t2 - {1'b0, P};
        end
        return fe_t'(t2);
    endfunction

endpackage

// File: rtl/femul.sv
// Field multiplier mod 2^255-19: full product on the start edge, reduction one clock later.
// Done pulses two cycles after the start cycle; any 255-bit operand is accepted.
module femul
    import fe_pkg::*;
(
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_start,
    input  fe_t  i_a,
    input  fe_t  i_b,
    output logic o_done,
    output fe_t  o_out
);

    logic [509:0] r_prod;
    logic         r_valid;
    logic         r_done;
    fe_t          r_out;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= i_start;
            r_done  <= r_valid;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_start) begin
            r_prod <= {255'd0, i_a} * {255'd0, i_b};
        end
        if (r_valid) begin
            r_out <= fe_reduce(r_prod);
        end
    end

    assign o_done = r_done;
    assign o_out  = r_out;

endmodule

// File: rtl/fe_pow.sv
// Left-to-right square-and-multiply: out = base^exp mod 2^255-19 using one femul.
// FE_POW_SKIP_LZ_EN: skip squarings of 1 while no set exponent bit has been seen.
//
//  state    | meaning
//  IDLE     | waiting for start
//  SQR_GO   | launch acc*acc
//  SQR_WAIT | wait for square, then test exponent bit
//  MUL_GO   | launch acc*base
//  MUL_WAIT | wait for multiply
//  NEXT     | advance bit index or finish
//  FIN      | done pulse, out valid
module fe_pow
    import fe_pkg::*;
#(
    parameter int EXP_W = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  fe_t              base,
    input  logic [EXP_W-1:0] exp,
    output logic             busy,
    output logic             done,
    output fe_t              out
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_W - 1);

    fe_pow_state_t    r_state;
    fe_pow_state_t    w_next;
    fe_t              r_b;
    logic [EXP_W-1:0] r_e;
    fe_t              r_acc;
    fe_t              r_out;
    logic [IDX_W-1:0] r_idx;
`ifdef FE_POW_SKIP_LZ_EN
    logic             r_seen;
`endif

    logic             w_mul_start;
    fe_t              w_mul_a;
    fe_t              w_mul_b;
    logic             w_mul_done;
    fe_t              w_mul_out;
    logic             w_bit;
    logic [IDX_W-1:0] w_idx_dn;

    assign w_bit    = r_e[r_idx];
    assign w_idx_dn = r_idx - IDX_W'(1);

    femul u_femul (
        .i_clock (clock),
        .i_reset (reset),
        .i_start (w_mul_start),
        .i_a     (w_mul_a),
        .i_b     (w_mul_b),
        .o_done  (w_mul_done),
        .o_out   (w_mul_out)
    );

    always_comb begin
        w_next      = r_state;
        w_mul_start = 1'b0;
        w_mul_a     = r_acc;
        w_mul_b     = r_acc;
        // b operand stays on base through the whole multiply so femul sees stable inputs
        if (r_state == ST_MUL_GO || r_state == ST_MUL_WAIT) begin
            w_mul_b = r_b;
        end
        case (r_state)
            ST_IDLE: begin
                if (start) begin
`ifdef FE_POW_SKIP_LZ_EN
                    w_next = exp[EXP_W-1] ? ST_MUL_GO : ST_NEXT;
`else
                    w_next = ST_SQR_GO;
`endif
                end
            end
            ST_SQR_GO: begin
                w_mul_start = 1'b1;
                w_next      = ST_SQR_WAIT;
            end
            ST_SQR_WAIT: begin
                if (w_mul_done) begin
                    w_next = w_bit ? ST_MUL_GO : ST_NEXT;
                end
            end
            ST_MUL_GO: begin
                w_mul_start = 1'b1;
                w_next      = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                if (w_mul_done) begin
                    w_next = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (r_idx == '0) begin
                    w_next = ST_FIN;
                end else begin
`ifdef FE_POW_SKIP_LZ_EN
                    if (!r_seen) begin
                        w_next = r_e[w_idx_dn] ? ST_MUL_GO : ST_NEXT;
                    end else begin
                        w_next = ST_SQR_GO;
                    end
`else
                    w_next = ST_SQR_GO;
`endif
                end
            end
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_b     <= '0;
            r_e     <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_idx   <= '0;
`ifdef FE_POW_SKIP_LZ_EN
            r_seen  <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_b    <= base;
                        r_e    <= exp;
                        r_acc  <= FE_ONE;
                        r_idx  <= IDX_TOP;
`ifdef FE_POW_SKIP_LZ_EN
                        r_seen <= 1'b0;
`endif
                    end
                end
                ST_SQR_WAIT, ST_MUL_WAIT: begin
                    if (w_mul_done) begin
                        r_acc <= w_mul_out;
                    end
                end
`ifdef FE_POW_SKIP_LZ_EN
                ST_MUL_GO: r_seen <= 1'b1;
`endif
                ST_NEXT: begin
                    // out is loaded on the way into FIN so it is already valid while done is high
                    if (r_idx == '0) begin
                        r_out <= r_acc;
                    end else begin
                        r_idx <= w_idx_dn;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_FIN);
    assign out  = r_out;

endmodule

// File: tb/tb_fe_pow.sv
// Directed bench for fe_pow: known powers mod 2^255-19, reset mid-operation, start handling.
module tb_fe_pow;
    import fe_pkg::*;

    localparam int   EXP_W = 255;
    localparam fe_t  P_TB  = fe_t'((256'd1 << 255) - 256'd19);
    localparam fe_t  HALF  = fe_t'((256'd1 << 254) - 256'd9);
`ifdef FE_POW_SKIP_LZ_EN
    localparam int   LAT_EXP0 = EXP_W + 2;
`else
    localparam int   LAT_EXP0 = 1 + EXP_W * 4 + 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start_i = 1'b0;
    fe_t              base_i = '0;
    logic [EXP_W-1:0] exp_i = '0;
    logic             busy_o;
    logic             done_o;
    fe_t              out_o;

    int n_checks = 0;
    int n_fail   = 0;

    fe_pow #(.EXP_W(EXP_W)) dut (
        .clock (clk),
        .reset (rst),
        .start (start_i),
        .base  (base_i),
        .exp   (exp_i),
        .busy  (busy_o),
        .done  (done_o),
        .out   (out_o)
    );

    always #5 clk = ~clk;

    // Pulses start for one cycle, then waits (bounded) for done; cycles = start cycle through done cycle.
    task automatic run_pow(input fe_t b, input logic [EXP_W-1:0] e,
                           output fe_t res, output int cycles, output bit timeout);
        int c;
        @(negedge clk);
        base_i  = b;
        exp_i   = e;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        c = 1;
        while (!done_o && c < 5000) begin
            @(negedge clk);
            c++;
        end
        timeout = !done_o;
        res     = out_o;
        cycles  = c + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || out_o !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b out=%h, required 0 0 0", busy_o, done_o, out_o);
        end
    endtask

    task automatic test_vectors();
        fe_t              bv [6];
        logic [EXP_W-1:0] ev [6];
        fe_t              xv [6];
        fe_t              r;
        int               cyc;
        bit               to;
        bv[0] = fe_t'(2);   ev[0] = EXP_W'(255);       xv[0] = fe_t'(19);
        bv[1] = fe_t'(2);   ev[1] = EXP_W'(256);       xv[1] = fe_t'(38);
        bv[2] = fe_t'(2);   ev[2] = P_TB - fe_t'(2);   xv[2] = HALF;
        bv[3] = fe_t'(5);   ev[3] = P_TB - fe_t'(1);   xv[3] = fe_t'(1);
        bv[4] = P_TB - fe_t'(1); ev[4] = EXP_W'(2);    xv[4] = fe_t'(1);
        bv[5] = fe_t'(0);   ev[5] = EXP_W'(5);         xv[5] = fe_t'(0);
        for (int i = 0; i < 6; i++) begin
            run_pow(bv[i], ev[i], r, cyc, to);
            n_checks++;
            if (to || r !== xv[i]) begin
                n_fail++;
                $display("FAIL vector_%0d: out=%h timeout=%b, required %h", i, r, to, xv[i]);
            end
        end
    endtask

    task automatic test_exp_zero();
        fe_t r;
        int  cyc;
        bit  to;
        run_pow(fe_t'(0), '0, r, cyc, to);
        n_checks++;
        if (to || r !== fe_t'(1)) begin
            n_fail++;
            $display("FAIL exp_zero_out: out=%h timeout=%b, required 1", r, to);
        end
        n_checks++;
        if (cyc !== LAT_EXP0) begin
            n_fail++;
            $display("FAIL exp_zero_latency: cycles=%0d, required %0d", cyc, LAT_EXP0);
        end
    endtask

    task automatic test_reset_mid_op();
        fe_t r;
        int  cyc;
        int  c;
        bit  to;
        bit  spurious;
        @(negedge clk);
        base_i  = fe_t'(3);
        exp_i   = EXP_W'(16);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        c = 0;
        while (dut.r_state != ST_MUL_WAIT && c < 5000) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (dut.r_state != ST_MUL_WAIT) begin
            n_fail++;
            $display("FAIL reach_mul_wait: waited %0d cycles without reaching it", c);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || out_o !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_state: busy=%b done=%b out=%h, required 0 0 0", busy_o, done_o, out_o);
        end
        spurious = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done_o || busy_o) spurious = 1'b1;
        end
        n_checks++;
        if (spurious !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_done: activity seen after reset=%b, required 0", spurious);
        end
        run_pow(fe_t'(3), EXP_W'(4), r, cyc, to);
        n_checks++;
        if (to || r !== fe_t'(81)) begin
            n_fail++;
            $display("FAIL after_reset_result: out=%h timeout=%b, required 51", r, to);
        end
    endtask

    task automatic test_start_while_busy();
        fe_t r;
        int  dones;
        int  c;
        r = '0;
        @(negedge clk);
        base_i  = fe_t'(3);
        exp_i   = EXP_W'(5);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_during_op: busy=%b, required 1", busy_o);
        end
        base_i  = fe_t'(7);
        exp_i   = EXP_W'(2);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        base_i  = '0;
        exp_i   = '0;
        dones = 0;
        c = 0;
        while (busy_o && c < 5000) begin
            if (done_o) begin
                dones++;
                r = out_o;
            end
            @(negedge clk);
            c++;
        end
        repeat (20) begin
            if (done_o) dones++;
            @(negedge clk);
        end
        n_checks++;
        if (dones !== 1 || r !== fe_t'(243)) begin
            n_fail++;
            $display("FAIL ignored_start: dones=%0d out=%h, required 1 and f3", dones, r);
        end
    endtask

    task automatic test_back_to_back();
        fe_t r;
        int  cyc;
        bit  to;
        run_pow(fe_t'(2), EXP_W'(10), r, cyc, to);
        n_checks++;
        if (to || r !== fe_t'(1024)) begin
            n_fail++;
            $display("FAIL b2b_first: out=%h timeout=%b, required 400", r, to);
        end
        // run_pow asserts start in the cycle right after done, when busy has just fallen
        run_pow(fe_t'(7), EXP_W'(3), r, cyc, to);
        n_checks++;
        if (to || r !== fe_t'(343)) begin
            n_fail++;
            $display("FAIL b2b_second: out=%h timeout=%b, required 157", r, to);
        end
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0 || out_o !== fe_t'(343)) begin
            n_fail++;
            $display("FAIL b2b_idle_hold: busy=%b out=%h, required 0 and 157", busy_o, out_o);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_exp_zero();
        test_reset_mid_op();
        test_start_while_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
